// File: rtl/led_gen_pkg.sv
// rtl/led_gen_pkg.sv - shared mode codes, direction type and pattern helpers for led_gen
package led_gen_pkg;

  localparam logic [1:0] MODE_RUN    = 2'b00;
  localparam logic [1:0] MODE_BIN    = 2'b01;
  localparam logic [1:0] MODE_ALT    = 2'b10;
  localparam logic [1:0] MODE_KNIGHT = 2'b11;

  // Upper bound on NUM_LEDS; alt_init builds a pattern this wide for the caller to slice.
  localparam int MAX_LEDS = 256;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic logic [MAX_LEDS-1:0] alt_init(input int width);
    logic [MAX_LEDS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      if ((i < width) && ((i % 2) == 0)) begin
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/led_gen_prescaler.sv
// rtl/led_gen_prescaler.sv - enable-gated clock divider producing one tick per STEP_CYCLES
module led_gen_prescaler #(
  parameter int STEP_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(STEP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] INC  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + INC;
    if (!enable || clear || at_last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && at_last;

endmodule

// File: rtl/led_gen.sv
// rtl/led_gen.sv - selectable LED animation (run, binary, alternating, Knight Rider)
module led_gen
  import led_gen_pkg::*;
#(
  parameter int NUM_LEDS    = 16,
  parameter int STEP_CYCLES = 10_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] leds
);

  localparam logic [MAX_LEDS-1:0] ALT_FULL  = alt_init(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] ALT_START = ALT_FULL[NUM_LEDS-1:0];
  localparam logic [NUM_LEDS-1:0] ONE_HOT0  = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  logic [1:0]          mode_q;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  dir_e                dir_q, dir_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                mode_change;
  logic                tick;

  assign mode_change = (mode != mode_q);

  led_gen_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (mode_change),
    .tick   (tick)
  );

  always_comb begin
    pat_d = pat_q;
    dir_d = dir_q;
    if (mode_change) begin
      dir_d = DIR_UP;
      case (mode)
        MODE_RUN: pat_d = ONE_HOT0;
        MODE_BIN: pat_d = '0;
        MODE_ALT: pat_d = ALT_START;
        default:  pat_d = ONE_HOT0;
      endcase
    end else if (tick) begin
      case (mode_q)
        MODE_RUN: pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
        MODE_BIN: pat_d = pat_q + ONE_HOT0;
        MODE_ALT: pat_d = ~pat_q;
        default: begin
          // Direction flips as the end bit is entered, so each end shows once per bounce.
          if (dir_q == DIR_UP) begin
            pat_d = pat_q << 1;
            if (pat_q[NUM_LEDS-2]) begin
              dir_d = DIR_DOWN;
            end
          end else begin
            pat_d = pat_q >> 1;
            if (pat_q[1]) begin
              dir_d = DIR_UP;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    leds_d = '0;
    if (enable) begin
      leds_d = pat_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_RUN;
      pat_q  <= ONE_HOT0;
      dir_q  <= DIR_UP;
      leds_q <= '0;
    end else begin
      mode_q <= mode;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      leds_q <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_led_gen.sv
// tb/tb_led_gen.sv - randomized self-checking bench for led_gen against a step-index model
module tb_led_gen;

  localparam int N    = 16;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic [N-1:0]  leds;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: each mode's pattern is a pure function of how many steps were taken.
  logic [1:0]    m_mode;
  int            m_s;
  int            m_cnt;
  logic [N-1:0]  m_leds;
  logic          load_req = 1'b0;

  always #5 clk = ~clk;

  led_gen #(
    .NUM_LEDS    (N),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .leds   (leds)
  );

  function automatic logic [N-1:0] pattern(input logic [1:0] m, input int s);
    logic [31:0] sv;
    int          r;
    int          p;
    sv = s;
    case (m)
      2'b00:   return 16'h0001 << (s % N);
      2'b01:   return sv[15:0];
      2'b10:   return ((s % 2) == 0) ? 16'h5555 : 16'hAAAA;
      default: begin
        r = s % (2 * N - 2);
        p = (r < N) ? r : (2 * N - 2 - r);
        return 16'h0001 << p;
      end
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 2'b00;
      m_s    = 0;
      m_cnt  = 0;
      m_leds = '0;
    end else begin
      m_leds = enable ? pattern(m_mode, m_s) : '0;
      if (mode != m_mode) begin
        m_mode = mode;
        m_s    = 0;
        m_cnt  = 0;
      end else if (!enable) begin
        m_cnt = 0;
      end else if (m_cnt == STEP - 1) begin
        m_cnt = 0;
        m_s   = m_s + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (load_req) begin
        m_s = 32'h0000_FFFE;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("leds_model", 32'(leds), 32'(m_leds));
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check(tag, 32'(leds), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic saw_ffff;
    logic saw_wrap;
    int   r;

    // 1: reset, then running light
    reset = 1'b0; enable = 1'b1; mode = 2'b00;
    cycles(2);
    check("reset_leds", 32'(leds), 32'h0);
    reset = 1'b1;
    cycles(1);
    check("run_first", 32'(leds), 32'h0001);
    cycles(STEP * N + 8);

    // 2: binary counter, then jump near the top to see the wrap
    mode = 2'b01;
    cycles(STEP * 10);
    enable = 1'b0;
    force dut.pat_q = 16'hFFFE;
    load_req = 1'b1;
    @(negedge clk);
    release dut.pat_q;
    load_req = 1'b0;
    enable = 1'b1;
    saw_ffff = 1'b0;
    saw_wrap = 1'b0;
    for (int i = 0; i < 3 * STEP + 2; i++) begin
      @(negedge clk);
      if (saw_ffff && leds == 16'h0000) saw_wrap = 1'b1;
      if (leds == 16'hFFFF) saw_ffff = 1'b1;
    end
    check("bin_wrap", 32'(saw_wrap), 32'h1);

    // 3: alternating
    mode = 2'b10;
    cycles(2);
    check("alt_start", 32'(leds), 32'h5555);
    cycles(STEP * 6);

    // 4: Knight Rider, two full bounces
    mode = 2'b11;
    cycles(STEP * (4 * N - 4) + 3);

    // 5: disable mid-pattern, then resume
    enable = 1'b0;
    cycles(1);
    check("disable_dark", 32'(leds), 32'h0);
    cycles(7);
    enable = 1'b1;
    cycles(STEP * 5);

    // 6: switch run -> knight mid-step, then async reset mid-step
    mode = 2'b00;
    cycles(STEP * 3 + 2);
    mode = 2'b11;
    cycles(2);
    check("knight_restart", 32'(leds), 32'h0001);
    cycles(STEP);
    check("knight_dir_up", 32'(leds), 32'h0002);
    cycles(1);
    async_reset_pulse("async_reset");
    mode = 2'b00;
    cycles(STEP * 3);

    // random mode / enable / reset traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 5) begin
        mode = 2'($urandom_range(0, 3));
      end else if (r < 9) begin
        enable = ~enable;
      end else if (r == 199) begin
        async_reset_pulse("rand_reset");
      end
      if (r != 199) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
